// File: rtl/video_fifo_line_reader.sv
// Raster timing generator that streams pixels from a first-word-fall-through FIFO.
// With VIDEO_FIFO_READER_RESYNC_EN defined, a frame that underflowed re-primes before the next frame.
module video_fifo_line_reader #(
  parameter int DATA_W   = 32,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter logic [DATA_W-1:0] FILL_DATA = '0
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              vid_de,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic [DATA_W-1:0] vid_data,
  output logic              frame_start,
  output logic              underflow
);

  localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC0_C = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC1_C = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC0_C = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC1_C = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       h_cnt_q, h_cnt_d;
  logic [11:0]       v_cnt_q, v_cnt_d;
  logic              frame_uf_q, frame_uf_d;
  logic              vid_de_q, vid_de_d;
  logic              vid_hs_q, vid_hs_d;
  logic              vid_vs_q, vid_vs_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;

  logic running_s, active_s, h_last_s, v_last_s, frame_end_s, pix_uf_s;

  assign running_s   = (state_q == ST_RUN);
  assign active_s    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign h_last_s    = (h_cnt_q == H_LAST_C);
  assign v_last_s    = (v_cnt_q == V_LAST_C);
  assign frame_end_s = running_s && h_last_s && v_last_s;
  // An active pixel with an empty FIFO head is an underflow; the pixel is filled.
  assign pix_uf_s    = running_s && active_s && !fifo_rd_vld;

  assign fifo_rd_en  = running_s && active_s;

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    frame_uf_d = frame_uf_q;
    underflow_d = underflow_q || pix_uf_s;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d    = 12'd0;
        v_cnt_d    = 12'd0;
        frame_uf_d = 1'b0;
        if (enable) begin
          state_d     = ST_PRIME;
          underflow_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_rd_vld) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        frame_uf_d = frame_uf_q || pix_uf_s;
        if (h_last_s) begin
          h_cnt_d = 12'd0;
          if (v_last_s) begin
            v_cnt_d = 12'd0;
          end else begin
            v_cnt_d = v_cnt_q + 12'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
        // Frame boundary is the only point where the FSM may leave RUN.
        if (frame_end_s) begin
          frame_uf_d = 1'b0;
          if (!enable) begin
            state_d = ST_IDLE;
`ifdef VIDEO_FIFO_READER_RESYNC_EN
          end else if (frame_uf_q || pix_uf_s) begin
            state_d = ST_PRIME;
`endif
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        h_cnt_d    = 12'd0;
        v_cnt_d    = 12'd0;
        frame_uf_d = 1'b0;
      end
    endcase

    vid_de_d      = running_s && active_s;
    vid_hs_d      = running_s && (h_cnt_q >= H_SYNC0_C) && (h_cnt_q < H_SYNC1_C);
    vid_vs_d      = running_s && (v_cnt_q >= V_SYNC0_C) && (v_cnt_q < V_SYNC1_C);
    frame_start_d = running_s && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    if (running_s && active_s) begin
      vid_data_d = fifo_rd_vld ? fifo_rd_data : FILL_DATA;
    end else begin
      vid_data_d = '0;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      frame_uf_q    <= 1'b0;
      vid_de_q      <= 1'b0;
      vid_hs_q      <= 1'b0;
      vid_vs_q      <= 1'b0;
      vid_data_q    <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_uf_q    <= frame_uf_d;
      vid_de_q      <= vid_de_d;
      vid_hs_q      <= vid_hs_d;
      vid_vs_q      <= vid_vs_d;
      vid_data_q    <= vid_data_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign vid_de      = vid_de_q;
  assign vid_hs      = vid_hs_q;
  assign vid_vs      = vid_vs_q;
  assign vid_data    = vid_data_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_fifo_line_reader.sv
// Bench for video_fifo_line_reader: scenario table, corner-case sequences and a random run
// against a frame-position reference model.
module tb_video_fifo_line_reader;

  localparam int DATA_W = 32;
  localparam int HA = 4, HF = 1, HSW = 1, HB = 1;
  localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam logic [DATA_W-1:0] FILL = 32'hA5A5_5A5A;

  logic              rd_clk = 1'b0;
  logic              rd_rst = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_vld = 1'b0;
  logic              fifo_rd_en;
  logic              vid_de, vid_hs, vid_vs, frame_start, underflow;
  logic [DATA_W-1:0] vid_data;

  video_fifo_line_reader #(
    .DATA_W(DATA_W), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .FILL_DATA(FILL)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_data(vid_data),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] fq[$];
  bit gate = 1'b1;

  // Reference model: mode 0 idle, 1 waiting for data, 2 streaming at frame position m_pos
  int m_mode = 0;
  int m_pos = 0;
  bit m_fuf = 1'b0;
  bit m_uf = 1'b0;
  bit e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;
  logic [DATA_W-1:0] e_data = '0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_act(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  task automatic refresh();
    fifo_rd_vld  = gate && (fq.size() != 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
  endtask

  task automatic m_reset();
    m_mode = 0; m_pos = 0; m_fuf = 1'b0; m_uf = 1'b0;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_data = '0;
  endtask

  task automatic m_step(input bit en, input bit vld, input logic [DATA_W-1:0] head);
    bit run;
    bit a;
    int h;
    int v;
    run = (m_mode == 2);
    h = m_pos % HT;
    v = m_pos / HT;
    a = run && m_act(m_pos);
    e_de   = a;
    e_hs   = run && (h >= HA + HF) && (h < HA + HF + HSW);
    e_vs   = run && (v >= VA + VF) && (v < VA + VF + VSW);
    e_fs   = run && (m_pos == 0);
    e_data = a ? (vld ? head : FILL) : '0;
    if (a && !vld) begin
      m_uf = 1'b1;
      m_fuf = 1'b1;
    end
    if (m_mode == 0) begin
      if (en) begin
        m_mode = 1;
        m_uf = 1'b0;
      end
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (vld) begin
        m_mode = 2;
        m_pos = 0;
      end
    end else begin
      if (m_pos == FT - 1) begin
        m_pos = 0;
        if (!en) m_mode = 0;
`ifdef VIDEO_FIFO_READER_RESYNC_EN
        else if (m_fuf) m_mode = 1;
`endif
        m_fuf = 1'b0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick(output bit popped);
    bit p;
    @(negedge rd_clk);
    chk("rd_en", 32'(fifo_rd_en), 32'((m_mode == 2) && m_act(m_pos)));
    chk("de", 32'(vid_de), 32'(e_de));
    chk("hs", 32'(vid_hs), 32'(e_hs));
    chk("vs", 32'(vid_vs), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("data", vid_data, e_data);
    chk("underflow", 32'(underflow), 32'(m_uf));
    p = fifo_rd_en && fifo_rd_vld;
    m_step(enable, fifo_rd_vld, fifo_rd_data);
    @(posedge rd_clk);
    #1;
    if (p) void'(fq.pop_front());
    refresh();
    popped = p;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rd_rst = 1'b1;
    #1;
    chk("rst_de", 32'(vid_de), 32'd0);
    chk("rst_hs", 32'(vid_hs), 32'd0);
    chk("rst_vs", 32'(vid_vs), 32'd0);
    chk("rst_data", vid_data, 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    m_reset();
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    refresh();
  endtask

  typedef struct {
    string name;
    int preload;
    int en_ticks;
    int ticks;
    int exp_pops;
    int exp_fs;
    int exp_de;
    bit exp_uf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit pop;
    int pops, nfs, nde, quiet;

    // Hand-counted totals: PRIME at edge 1, RUN at edge 2, frame k visible from edge 3+35k
    vecs[0] = '{"one_frame_en_drop", 8, 3, 50, 8, 1, 8, 1'b0};
    vecs[1] = '{"three_frames", 24, -1, 107, 24, 3, 24, 1'b0};
`ifdef VIDEO_FIFO_READER_RESYNC_EN
    vecs[2] = '{"underflow_after5", 5, -1, 72, 5, 1, 8, 1'b1};
`else
    vecs[2] = '{"underflow_after5", 5, -1, 72, 5, 2, 16, 1'b1};
`endif
    vecs[3] = '{"empty_prime", 0, -1, 20, 0, 0, 0, 1'b0};

    #2;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fq.delete();
      for (int i = 0; i < vecs[r].preload; i++) fq.push_back(32'h10 + 32'(i));
      gate = 1'b1;
      enable = 1'b1;
      refresh();
      pops = 0; nfs = 0; nde = 0;
      for (int t = 0; t < vecs[r].ticks; t++) begin
        if (t == vecs[r].en_ticks) enable = 1'b0;
        tick(pop);
        pops += int'(pop);
        nfs += int'(frame_start);
        nde += int'(vid_de);
      end
      chk({vecs[r].name, "_pops"}, 32'(pops), 32'(vecs[r].exp_pops));
      chk({vecs[r].name, "_fs"}, 32'(nfs), 32'(vecs[r].exp_fs));
      chk({vecs[r].name, "_de"}, 32'(nde), 32'(vecs[r].exp_de));
      chk({vecs[r].name, "_uf"}, 32'(underflow), 32'(vecs[r].exp_uf));
    end

    // Long PRIME wait, then streaming begins right after valid rises
    do_reset();
    fq.delete();
    enable = 1'b1;
    refresh();
    quiet = 0;
    for (int t = 0; t < 20; t++) begin
      tick(pop);
      quiet += int'(fifo_rd_en | vid_hs | vid_vs | vid_de);
    end
    chk("prime_quiet", 32'(quiet), 32'd0);
    for (int i = 0; i < 8; i++) fq.push_back(32'h10 + 32'(i));
    refresh();
    tick(pop);
    chk("prime_first_rd_en", 32'(fifo_rd_en), 32'd1);
    tick(pop);
    chk("prime_first_fs", 32'(frame_start), 32'd1);
    chk("prime_first_de", 32'(vid_de), 32'd1);
    chk("prime_first_data", vid_data, 32'h10);

    // Reset in the middle of the first active line, then restart from the FIFO head
    do_reset();
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(32'h10 + 32'(i));
    enable = 1'b1;
    refresh();
    for (int t = 0; t < 4; t++) tick(pop);
    chk("midline_de", 32'(vid_de), 32'd1);
    chk("midline_data", vid_data, 32'h11);
    do_reset();
    enable = 1'b1;
    tick(pop);
    chk("restart_prime_rd_en", 32'(fifo_rd_en), 32'd0);
    tick(pop);
    chk("restart_run_rd_en", 32'(fifo_rd_en), 32'd1);
    tick(pop);
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_data", vid_data, 32'h12);

    // Random FIFO availability, refills and enable toggling
    do_reset();
    fq.delete();
    enable = 1'b1;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(63) == 0) enable = ~enable;
      gate = ($urandom_range(7) != 0);
      if (fq.size() < 6) begin
        for (int k = 0; k < int'($urandom_range(3)); k++) fq.push_back($urandom);
      end
      refresh();
      tick(pop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
